chaos_iterator: RTL and testbench
=================================

# chaos_iterator

Logistic-map iteration engine: computes x(n+1) = mu·x(n)·(1−x(n)) in unsigned fixed point, one iteration per rising edge of the step tick. It sits downstream of the sample parameter selector and consumes its mu (2.16), maxrepeat and calc_clock outputs. It streams each new x to the plotting/output logic with a one-cycle valid strobe, and flags completion after maxrepeat iterations.

## Interface
- MU_W, 18, mu width, unsigned 2.16 format
- X_W, 16, state width, unsigned 0.16 format (x in [0,1))
- CNT_W, 10, iteration counter width

- CLK  in  1  system clock; all logic on posedge
- RST  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- x0  in  X_W  initial value, latched on accepted start
- mu  in  MU_W  map parameter, latched on accepted start
- maxrepeat  in  CNT_W  iteration count, latched on accepted start
- step_tick  in  1  slow iteration pacing signal (calc_clock), sampled as data on CLK
- x_out  out  X_W  current x; x0 after start, then each new iterate
- x_valid  out  1  one-cycle pulse when x_out takes a new iterate
- iter_count  out  CNT_W  iterations completed in current run
- busy  out  1  high from accepted start until DONE entered
- done  out  1  one-cycle pulse on entry to DONE
- overrun  out  1  sticky: a step_tick edge arrived while not in WAIT; cleared by accepted start

## Operation
- States: IDLE, WAIT, MUL1, MUL2, WRITE, DONE.
- IDLE/DONE + start: latch x0, mu, maxrepeat; x_out←x0; iter_count←0; overrun←0. If maxrepeat==0 go DONE, else go WAIT.
- Edge detect: tick_q registers step_tick; edge = step_tick & ~tick_q.
- WAIT + edge → MUL1. An edge in any other state is dropped, not queued, and sets overrun (except in IDLE/DONE).
- MUL1: onemx = 2^X_W − x_out (X_W+1 bits, so x=0 gives exactly 1.0); p1 = (x_out·onemx)[2·X_W−1:X_W]. Result fits in 0.16; maximum 0x4000.
- MUL2: p2 = mu·p1 (MU_W+X_W bits); xn = p2[2·X_W−1:X_W]. Truncation only, no rounding. Because mu<4 and p1≤0.25, xn<1 and no saturation is needed.
- WRITE: x_out←xn; x_valid=1; iter_count+1. If the new count equals latched maxrepeat go DONE, else go WAIT.
- DONE: done pulses for one cycle on entry. x_out and iter_count hold. State remains DONE until start.
- start outside IDLE/DONE: ignored. Input mu/maxrepeat changes during a run have no effect.
- Reset mid-run: immediate return to IDLE. Reset values: x_out=0, x_valid=0, iter_count=0, busy=0, done=0, overrun=0, tick_q=0.

## Timing
- Accepted start at cycle T: x_out=x0 and busy=1 from T+1.
- Edge sampled at cycle E (in WAIT): MUL1 at E+1, MUL2 at E+2, x_valid and new x_out at E+3.
- Minimum tick period for loss-free operation is 4 CLK cycles. Shorter spacing sets overrun.
- done asserts in the cycle after the final x_valid; busy deasserts in that same cycle.
- start with maxrepeat==0 at T: done=1 at T+1, busy=0, no x_valid.

## Configuration
- CHAOS_FIXPT_EXIT_EN defined: in WRITE, if xn equals the previous x_out, the run terminates early. It goes to DONE, with iter_count including that iteration and x_valid still pulsed.
- Undefined: always runs exactly maxrepeat iterations.

## Structure
- Shared package chaos_pkg holds:
  - MU_W, X_W and CNT_W constants
  - the state enum type
  - a ONE_X constant (2^X_W), shared with the parameter selector and the display logic
- One sub-module, logistic_mul, holds the two-stage datapath (x, mu in; registered p1 and xn out, stage enables from the FSM).

## Test plan
- mu=0x0CCCC (0.8), x0=0x8000, maxrepeat=3, tick every 64 cycles → first x_valid at edge+3 with x_out=0x3333; exactly 3 x_valid pulses; done follows; iter_count=3.
- mu=0x3FFFF, x0=0x0000, maxrepeat=5 → x_out stays 0. With CHAOS_FIXPT_EXIT_EN, done after 1 iteration with iter_count=1; without it, 5 iterations.
- maxrepeat=0, start → done at T+1, no x_valid, x_out=x0, busy never high beyond T+1.
- Ticks spaced 2 cycles apart → overrun=1, one iteration per accepted edge only. A new start clears overrun.
- RST asserted during MUL2 → all outputs zero asynchronously. After release, ticks cause no x_valid until a start.
- start pulsed during a run with different mu → ignored; iterates match the originally latched mu.

Source files
------------

// File: rtl/chaos_pkg.sv
// chaos_pkg: constants and the FSM state type shared by the logistic-map
// engine, the parameter selector and the display logic.
// Widths: mu is unsigned 2.16, x is unsigned 0.16, iteration counter CNT_W bits.
package chaos_pkg;

  localparam int MU_W  = 18;
  localparam int X_W   = 16;
  localparam int CNT_W = 10;

  // Exactly 1.0 in 0.16 format; needs one extra integer bit.
  localparam logic [X_W:0] ONE_X = {1'b1, {X_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MUL1,
    S_MUL2,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/chaos_iterator_logistic_mul.sv
// logistic_mul: two-stage datapath for x(n+1) = mu*x*(1-x), truncating.
// Latency: p1 registered one cycle after en1, xn one cycle after en2.
// Backpressure: none; stages advance only when the FSM pulses en1/en2.
// Ports: CLK/RST (async active-high), load/x0 preload the x register,
//   en1/en2 stage enables, x operand (current x), mu, p1 and xn registered.
module logistic_mul
  import chaos_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en1,
  input  logic             en2,
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x,
  input  logic [MU_W-1:0]  mu,
  output logic [X_W-1:0]   p1,
  output logic [X_W-1:0]   xn
);

  logic [X_W:0]          onemx;
  logic [2*X_W:0]        x_ext;
  logic [2*X_W:0]        onemx_ext;
  logic [MU_W+X_W-1:0]   mu_ext;
  logic [MU_W+X_W-1:0]   p1_ext;

  // onemx carries X_W+1 bits so that x=0 yields exactly 1.0.
  always_comb begin
    onemx     = ONE_X - {1'b0, x};
    x_ext     = {{(X_W+1){1'b0}}, x};
    onemx_ext = {{X_W{1'b0}}, onemx};
    mu_ext    = {{X_W{1'b0}}, mu};
    p1_ext    = {{MU_W{1'b0}}, p1};
  end

  // x*(1-x) never exceeds 0.25 and mu*p1 stays below 1.0, so taking the
  // middle X_W bits of each product is a pure truncation with no overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p1 <= '0;
      xn <= '0;
    end else begin
      if (en1)
        p1 <= X_W'((x_ext * onemx_ext) >> X_W);
      if (load)
        xn <= x0;
      else if (en2)
        xn <= X_W'((mu_ext * p1_ext) >> X_W);
    end
  end

endmodule

// File: rtl/chaos_iterator.sv
// chaos_iterator: logistic-map engine, one iteration per rising step_tick.
// Latency: edge seen in WAIT -> new x_out with x_valid three cycles later.
// Backpressure: none; ticks outside WAIT are dropped and flag sticky overrun.
// Ports: CLK, RST (async active-high), start/x0/mu/maxrepeat run request,
//   step_tick pacing input, x_out/x_valid stream, iter_count, busy, done,
//   overrun. Optional macro CHAOS_FIXPT_EXIT_EN: stop early when an iterate
//   equals its predecessor.
module chaos_iterator
  import chaos_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [MU_W-1:0]  mu,
  input  logic [CNT_W-1:0] maxrepeat,
  input  logic             step_tick,
  output logic [X_W-1:0]   x_out,
  output logic             x_valid,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_t           state;
  logic             tick_q;
  logic             tick_edge;
  logic             start_ok;
  logic [MU_W-1:0]  mu_q;
  logic [CNT_W-1:0] maxrep_q;
  logic             stop_now;
`ifdef CHAOS_FIXPT_EXIT_EN
  logic [X_W-1:0]   x_prev;
`endif

  assign tick_edge = step_tick & ~tick_q;
  assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE));

`ifdef CHAOS_FIXPT_EXIT_EN
  assign stop_now = (iter_count == maxrep_q) | (x_out == x_prev);
`else
  assign stop_now = (iter_count == maxrep_q);
`endif

  // The datapath's xn register doubles as x_out: preloaded with x0 on
  // start, overwritten by each new iterate at the end of MUL2.
  logistic_mul u_mul (
    .CLK  (CLK),
    .RST  (RST),
    .load (start_ok),
    .en1  (state == S_MUL1),
    .en2  (state == S_MUL2),
    .x0   (x0),
    .x    (x_out),
    .mu   (mu_q),
    .p1   (),
    .xn   (x_out)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      tick_q     <= 1'b0;
      mu_q       <= '0;
      maxrep_q   <= '0;
      x_valid    <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
`ifdef CHAOS_FIXPT_EXIT_EN
      x_prev     <= '0;
`endif
    end else begin
      tick_q  <= step_tick;
      x_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mu_q       <= mu;
            maxrep_q   <= maxrepeat;
            iter_count <= '0;
            overrun    <= 1'b0;
            if (maxrepeat == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (tick_edge)
            state <= S_MUL1;
        end
        S_MUL1: begin
          state <= S_MUL2;
`ifdef CHAOS_FIXPT_EXIT_EN
          x_prev <= x_out;
`endif
        end
        // x_valid and the count are raised here so they line up with the
        // cycle in which the new x_out first appears (the WRITE cycle).
        S_MUL2: begin
          state      <= S_WRITE;
          x_valid    <= 1'b1;
          iter_count <= iter_count + CNT_W'(1);
        end
        S_WRITE: begin
          if (stop_now) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (tick_edge && (state == S_MUL1 || state == S_MUL2 || state == S_WRITE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chaos_iterator.sv
module tb_chaos_iterator;
  import chaos_pkg::*;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic             step_tick = 1'b0;
  logic [X_W-1:0]   x0 = '0;
  logic [MU_W-1:0]  mu = '0;
  logic [CNT_W-1:0] maxrepeat = '0;
  logic [X_W-1:0]   x_out;
  logic             x_valid;
  logic [CNT_W-1:0] iter_count;
  logic             busy;
  logic             done;
  logic             overrun;

  always #5 CLK = ~CLK;

  chaos_iterator dut (
    .CLK(CLK), .RST(RST), .start(start), .x0(x0), .mu(mu),
    .maxrepeat(maxrepeat), .step_tick(step_tick), .x_out(x_out),
    .x_valid(x_valid), .iter_count(iter_count), .busy(busy),
    .done(done), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_xv = 0;
  int done_cyc = 0;
  logic [X_W-1:0] vq[$];
  logic [X_W-1:0] eq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (x_valid === 1'b1) begin
      vq.push_back(x_out);
      last_xv = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: the logistic map in plain integer arithmetic.
  function automatic logic [15:0] lmap(input logic [15:0] x, input logic [17:0] m);
    longint xi, p1, p2;
    xi = longint'(x);
    p1 = (xi * (65536 - xi)) / 65536;
    p2 = (longint'(m) * p1) / 65536;
    return p2[15:0];
  endfunction

  task automatic build_exp(input logic [15:0] xs, input logic [17:0] m, input int mr);
    logic [15:0] x, xn;
    eq.delete();
    x = xs;
    for (int i = 0; i < mr; i++) begin
      xn = lmap(x, m);
      eq.push_back(xn);
`ifdef CHAOS_FIXPT_EXIT_EN
      if (xn == x) break;
`endif
      x = xn;
    end
  endtask

  task automatic do_start(input logic [15:0] a, input logic [17:0] m, input logic [9:0] r);
    @(posedge CLK); #1;
    x0 = a; mu = m; maxrepeat = r; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    x0 = X_W'($urandom); mu = MU_W'($urandom); maxrepeat = CNT_W'($urandom);
  endtask

  task automatic tick(input int period);
    @(posedge CLK); #1 step_tick = 1'b1;
    @(posedge CLK); #1 step_tick = 1'b0;
    repeat (period - 2) @(posedge CLK);
  endtask

  task automatic run_to_done(input int period, input int max_ticks, output bit ok);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < max_ticks) begin
      tick(period);
      n++;
    end
    repeat (6) @(posedge CLK);
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    RST = 1'b1; x0 = 16'hABCD; mu = 18'h3FFFF; maxrepeat = 10'd7; start = 1'b1;
    repeat (3) @(negedge CLK);
    tests++; if (x_out !== '0) begin fails++; $display("FAIL reset_x_out: got %h want 0", x_out); end
    tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
    tests++; if (iter_count !== '0) begin fails++; $display("FAIL reset_iter: got %0d want 0", iter_count); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got busy=%b done=%b ovr=%b want 000", busy, done, overrun); end
    start = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_basic();
    bit ok;
    vq.delete();
    build_exp(16'h8000, 18'h0CCCC, 3);
    do_start(16'h8000, 18'h0CCCC, 10'd3);
    @(negedge CLK);
    tests++; if (x_out !== 16'h8000 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_start: got x=%h busy=%b want x=8000 busy=1", x_out, busy); end
    @(posedge CLK); #1 step_tick = 1'b1;
    @(posedge CLK); #1 step_tick = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", x_valid); end
    @(negedge CLK);
    tests++; if (x_valid !== 1'b1 || x_out !== 16'h3333 || iter_count !== 10'd1) begin
      fails++; $display("FAIL basic_first: got v=%b x=%h n=%0d want v=1 x=3333 n=1", x_valid, x_out, iter_count); end
    repeat (60) @(posedge CLK);
    run_to_done(64, 10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout: got no done want done"); end
    tests++; if (vq.size() != eq.size()) begin fails++; $display("FAIL basic_count: got %0d want %0d", vq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
      tests++; if (vq[i] !== eq[i]) begin fails++; $display("FAIL basic_x%0d: got %h want %h", i, vq[i], eq[i]); end
    end
    tests++; if (iter_count !== CNT_W'(eq.size())) begin fails++; $display("FAIL basic_iter: got %0d want %0d", iter_count, eq.size()); end
    tests++; if (done_cyc != last_xv + 1) begin fails++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_xv + 1); end
    tests++; if (busy !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL basic_end_flags: got busy=%b ovr=%b want 00", busy, overrun); end
  endtask

  task automatic test_zero_x();
    bit ok;
    int want;
`ifdef CHAOS_FIXPT_EXIT_EN
    want = 1;
`else
    want = 5;
`endif
    vq.delete();
    do_start(16'h0000, 18'h3FFFF, 10'd5);
    run_to_done(8, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_done_timeout: got no done want done"); end
    tests++; if (iter_count !== CNT_W'(want) || vq.size() != want) begin
      fails++; $display("FAIL zero_iter: got n=%0d pulses=%0d want %0d", iter_count, vq.size(), want); end
    foreach (vq[i]) begin
      tests++; if (vq[i] !== 16'h0000) begin fails++; $display("FAIL zero_x%0d: got %h want 0000", i, vq[i]); end
    end
  endtask

  task automatic test_maxrep_zero();
    logic [15:0] a;
    int v0;
    a = 16'($urandom_range(1, 65535));
    vq.delete();
    v0 = done_cnt;
    do_start(a, 18'h2AAAA, 10'd0);
    @(negedge CLK);
    tests++; if (done !== 1'b1 || busy !== 1'b0 || x_out !== a) begin
      fails++; $display("FAIL mr0_T1: got done=%b busy=%b x=%h want 1 0 %h", done, busy, x_out, a); end
    @(negedge CLK);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mr0_T2: got done=%b busy=%b want 0 0", done, busy); end
    tick(5); tick(5);
    tests++; if (vq.size() != 0 || iter_count !== '0 || done_cnt != v0 + 1) begin
      fails++; $display("FAIL mr0_quiet: got pulses=%0d n=%0d dones=%0d want 0 0 1", vq.size(), iter_count, done_cnt - v0); end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [15:0] a;
    logic [17:0] m;
    a = 16'($urandom_range(1, 65535));
    m = 18'($urandom_range(18'h20000, 18'h3FFFF));
    vq.delete();
    build_exp(a, m, 4);
    do_start(a, m, 10'd4);
    run_to_done(2, 40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovr_done_timeout: got no done want done"); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    tests++; if (vq.size() != eq.size()) begin fails++; $display("FAIL ovr_count: got %0d want %0d", vq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
      tests++; if (vq[i] !== eq[i]) begin fails++; $display("FAIL ovr_x%0d: got %h want %h", i, vq[i], eq[i]); end
    end
    do_start(a, m, 10'd2);
    @(negedge CLK);
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    run_to_done(8, 10, ok);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    a = 16'($urandom_range(1, 65535));
    vq.delete();
    do_start(a, 18'h3C000, 10'd3);
    @(posedge CLK); #1 step_tick = 1'b1;
    @(posedge CLK); #1 step_tick = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    tests++; if (x_out !== '0 || x_valid !== 1'b0 || iter_count !== '0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL rst_mid: got x=%h v=%b n=%0d busy=%b done=%b ovr=%b want all 0",
                        x_out, x_valid, iter_count, busy, done, overrun); end
    @(posedge CLK); #1 RST = 1'b0;
    tick(6); tick(6); tick(6);
    tests++; if (vq.size() != 0 || busy !== 1'b0 || x_out !== '0) begin
      fails++; $display("FAIL rst_after: got pulses=%0d busy=%b x=%h want 0 0 0000", vq.size(), busy, x_out); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    vq.delete();
    build_exp(16'h2000, 18'h3C000, 4);
    do_start(16'h2000, 18'h3C000, 10'd4);
    tick(8);
    @(posedge CLK); #1 start = 1'b1; mu = 18'h10000; x0 = 16'h7777; maxrepeat = 10'd1;
    @(posedge CLK); #1 start = 1'b0;
    @(negedge CLK);
    tests++; if (busy !== 1'b1 || iter_count !== 10'd1) begin
      fails++; $display("FAIL ign_busy: got busy=%b n=%0d want 1 1", busy, iter_count); end
    run_to_done(8, 20, ok);
    tests++; if (!ok || vq.size() != eq.size()) begin fails++; $display("FAIL ign_count: got %0d want %0d", vq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
      tests++; if (vq[i] !== eq[i]) begin fails++; $display("FAIL ign_x%0d: got %h want %h", i, vq[i], eq[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] a;
    logic [17:0] m;
    int mr, per;
    for (int r = 0; r < 8; r++) begin
      a   = 16'($urandom);
      m   = 18'($urandom);
      mr  = $urandom_range(1, 6);
      per = $urandom_range(4, 12);
      vq.delete();
      build_exp(a, m, mr);
      do_start(a, m, 10'(mr));
      run_to_done(per, 20, ok);
      tests++; if (!ok || vq.size() != eq.size()) begin
        fails++; $display("FAIL rnd%0d_count: got %0d want %0d", r, vq.size(), eq.size()); end
      for (int i = 0; i < eq.size() && i < vq.size(); i++) begin
        tests++; if (vq[i] !== eq[i]) begin fails++; $display("FAIL rnd%0d_x%0d: got %h want %h", r, i, vq[i], eq[i]); end
      end
      tests++; if (iter_count !== CNT_W'(eq.size()) || overrun !== 1'b0 || done_cyc != last_xv + 1) begin
        fails++; $display("FAIL rnd%0d_end: got n=%0d ovr=%b dgap=%0d want %0d 0 1",
                          r, iter_count, overrun, done_cyc - last_xv, eq.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_x();
    test_maxrep_zero();
    test_overrun();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
